// File: rtl/amp3_scheduler.sv
// amp3_scheduler
//   Two-requester round-robin arbiter feeding a stereo-sample FIFO, drained by
//   a three-state sequencer that hands one sample at a time to an I2S
//   transmitter.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   req0_valid/ready/R/L       requester 0 stereo-sample handshake
//   req1_valid/ready/R/L       requester 1 stereo-sample handshake
//   tx_enable                  one-cycle start pulse to the transmitter
//   tx_dataR, tx_dataL         registered sample presented to the transmitter
//   tx_idle                    transmitter ready for a new sample
//   fifo_count                 FIFO occupancy, 0..DEPTH
//   underrun                   sticky: transmitter idle with FIFO empty while streaming
//   underrun_clr               synchronous clear of underrun and the streaming flag
//   o_dbg_state                sequencer state (0 IDLE, 1 WAIT_BUSY, 2 WAIT_IDLE)
//
// Handshake: a sample moves on requester k at a rising edge where both
// reqk_valid and reqk_ready are 1. ready is a combinational function of the
// valids, the last grant and FIFO fullness only; it never looks at tx_idle,
// and at most one ready is high in any cycle.
module amp3_scheduler #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_W-1:0]        req0_R,
    input  logic [DATA_W-1:0]        req0_L,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_W-1:0]        req1_R,
    input  logic [DATA_W-1:0]        req1_L,
    output logic                     tx_enable,
    output logic [DATA_W-1:0]        tx_dataR,
    output logic [DATA_W-1:0]        tx_dataL,
    input  logic                     tx_idle,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     underrun,
    input  logic                     underrun_clr,
    output logic [1:0]               o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_IDLE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [DATA_W-1:0]   r_mem_r [DEPTH];
    logic [DATA_W-1:0]   r_mem_l [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;

    // 1 means requester 1 won last, so requester 0 wins the next tie.
    logic                r_last_grant;
    logic                r_streaming;
    logic                r_underrun;
    logic                r_tx_enable;
    logic [DATA_W-1:0]   r_tx_r;
    logic [DATA_W-1:0]   r_tx_l;

    logic                w_full;
    logic                w_empty;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_push;
    logic                w_pop;
    logic                w_under_set;
    logic [DATA_W-1:0]   w_push_r;
    logic [DATA_W-1:0]   w_push_l;

    // Arbitration. rst gates the readies so nothing is offered during reset.
    always_comb begin
        w_full   = (r_count == CNT_FULL);
        w_empty  = (r_count == '0);
        w_gnt0   = rst && !w_full && req0_valid && (!req1_valid || r_last_grant);
        w_gnt1   = rst && !w_full && req1_valid && (!req0_valid || !r_last_grant);
        w_push   = w_gnt0 || w_gnt1;
        w_push_r = w_gnt0 ? req0_R : req1_R;
        w_push_l = w_gnt0 ? req0_L : req1_L;
    end

    // Sequencer next state and pop decision.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && tx_idle) begin
                    w_pop        = 1'b1;
                    w_next_state = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!tx_idle) begin
                    w_next_state = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (tx_idle) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        w_under_set = (r_state == S_IDLE) && r_streaming && tx_idle && w_empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_r[i] <= '0;
                r_mem_l[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= 1'b1;
            r_streaming  <= 1'b0;
            r_underrun   <= 1'b0;
            r_tx_enable  <= 1'b0;
            r_tx_r       <= '0;
            r_tx_l       <= '0;
        end else begin
            if (w_push) begin
                r_mem_r[r_wr_ptr] <= w_push_r;
                r_mem_l[r_wr_ptr] <= w_push_l;
                r_wr_ptr          <= r_wr_ptr + PTR_ONE;
                r_last_grant      <= w_gnt1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_tx_r   <= r_mem_r[r_rd_ptr];
                r_tx_l   <= r_mem_l[r_rd_ptr];
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            r_tx_enable <= w_pop;

            // A start in the same cycle as a clear begins a new stream, so
            // the start wins for the streaming flag.
            if (w_pop) begin
                r_streaming <= 1'b1;
            end else if (underrun_clr) begin
                r_streaming <= 1'b0;
            end

            if (underrun_clr) begin
                r_underrun <= 1'b0;
            end else if (w_under_set) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign tx_enable   = r_tx_enable;
    assign tx_dataR    = r_tx_r;
    assign tx_dataL    = r_tx_l;
    assign fifo_count  = r_count;
    assign underrun    = r_underrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_amp3_scheduler.sv
// Self-checking bench for amp3_scheduler. A behavioural model (sample queue,
// last-winner integer, transmitter-handshake flags) predicts readies,
// occupancy, start pulses, presented data and the underrun flag every cycle.
module tb_amp3_scheduler;

    localparam int DW    = 12;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [DW-1:0]   req0_R, req0_L, req1_R, req1_L;
    logic            tx_enable;
    logic [DW-1:0]   tx_dataR, tx_dataL;
    logic            tx_idle;
    logic [2:0]      fifo_count;
    logic            underrun;
    logic            underrun_clr;
    logic [1:0]      dbg_state;

    amp3_scheduler #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_R       (req0_R),
        .req0_L       (req0_L),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_R       (req1_R),
        .req1_L       (req1_L),
        .tx_enable    (tx_enable),
        .tx_dataR     (tx_dataR),
        .tx_dataL     (tx_dataL),
        .tx_idle      (tx_idle),
        .fifo_count   (fifo_count),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [2*DW-1:0] exp_q[$];   // samples in arrival order {R,L}
    int              m_last;     // requester that won most recently
    bit              m_need_low, m_need_high;
    bit              m_stream, m_under, m_en;
    logic [DW-1:0]   m_dr, m_dl;
    int              grants[$];
    int              n_en;

    // transmitter stimulus: 0 random, 1 responsive (busy_len low after start), 2 held busy
    int tx_mode  = 1;
    int busy_len = 3;
    int tx_cnt   = 0;
    bit saw_en   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        grants.delete();
        m_last      = 1;
        m_need_low  = 0;
        m_need_high = 0;
        m_stream    = 0;
        m_under     = 0;
        m_en        = 0;
        m_dr        = '0;
        m_dl        = '0;
        tx_cnt      = 0;
        saw_en      = 0;
    endtask

    // Called at a falling edge; holds reset for two cycles with valids high.
    task automatic do_reset();
        rst          = 1'b0;
        req0_valid   = 1'b1;
        req1_valid   = 1'b1;
        underrun_clr = 1'b0;
        tx_idle      = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'(0));
        chk("rst_ready1", 32'(req1_ready), 32'(0));
        chk("rst_count",  32'(fifo_count), 32'(0));
        chk("rst_en",     32'(tx_enable),  32'(0));
        chk("rst_dr",     32'(tx_dataR),   32'(0));
        chk("rst_dl",     32'(tx_dataL),   32'(0));
        chk("rst_under",  32'(underrun),   32'(0));
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst        = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    task automatic step(input logic v0, input logic v1, input logic clr,
                        input logic [DW-1:0] a_r, input logic [DW-1:0] a_l,
                        input logic [DW-1:0] b_r, input logic [DW-1:0] b_l);
        bit full, e0, e1, idle_ph, start, uset;
        req0_valid   = v0;
        req1_valid   = v1;
        req0_R       = a_r;
        req0_L       = a_l;
        req1_R       = b_r;
        req1_L       = b_l;
        underrun_clr = clr;
        case (tx_mode)
            0: tx_idle = ($urandom_range(0, 9) < 7);
            1: begin
                if (saw_en) tx_cnt = busy_len;
                else if (tx_cnt > 0) tx_cnt--;
                tx_idle = (tx_cnt == 0);
            end
            default: tx_idle = 1'b0;
        endcase
        #1;
        full = (exp_q.size() == DEPTH);
        e0 = v0 && !full && (!v1 || m_last == 1);
        e1 = v1 && !full && (!v0 || m_last == 0);
        chk("ready0", 32'(req0_ready), 32'(e0));
        chk("ready1", 32'(req1_ready), 32'(e1));
        chk("count",  32'(fifo_count), 32'(exp_q.size()));
        chk("tx_en",  32'(tx_enable),  32'(m_en));
        chk("dataR",  32'(tx_dataR),   32'(m_dr));
        chk("dataL",  32'(tx_dataL),   32'(m_dl));
        chk("under",  32'(underrun),   32'(m_under));
        saw_en = tx_enable;
        if (tx_enable) n_en++;

        // What the coming rising edge does, judged on pre-edge state.
        idle_ph = !m_need_low && !m_need_high;
        start   = idle_ph && (exp_q.size() > 0) && tx_idle;
        uset    = idle_ph && m_stream && tx_idle && (exp_q.size() == 0);
        if (e0) begin
            exp_q.push_back({a_r, a_l});
            m_last = 0;
            grants.push_back(0);
        end else if (e1) begin
            exp_q.push_back({b_r, b_l});
            m_last = 1;
            grants.push_back(1);
        end
        if (start) begin
            m_need_low = 1;
            {m_dr, m_dl} = exp_q.pop_front();
        end else if (m_need_low && !tx_idle) begin
            m_need_low  = 0;
            m_need_high = 1;
        end else if (m_need_high && tx_idle) begin
            m_need_high = 0;
        end
        m_en = start;
        if (start) m_stream = 1;
        else if (clr) m_stream = 0;
        if (clr) m_under = 0;
        else if (uset) m_under = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        int exp_g[4];
        int en_before;
        rst          = 1'b0;
        req0_valid   = 1'b0;
        req1_valid   = 1'b0;
        req0_R = '0; req0_L = '0; req1_R = '0; req1_L = '0;
        underrun_clr = 1'b0;
        tx_idle      = 1'b1;
        n_en         = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single source sample with the transmitter idle.
        tx_mode  = 1;
        busy_len = 3;
        step(1'b1, 1'b0, 1'b0, 12'hA5A, 12'h468, 12'h111, 12'h222);
        idle_steps(1);
        chk("single_en", 32'(tx_enable), 32'(1));
        chk("single_R",  32'(tx_dataR),  32'(12'hA5A));
        chk("single_L",  32'(tx_dataL),  32'(12'h468));
        chk("single_cnt", 32'(fifo_count), 32'(0));

        // Underrun once the transmitter returns idle with nothing queued.
        idle_steps(10);
        chk("underrun_set", 32'(underrun), 32'(1));
        idle_steps(5);
        chk("underrun_hold", 32'(underrun), 32'(1));
        step(1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
        chk("underrun_clr", 32'(underrun), 32'(0));
        idle_steps(5);
        chk("underrun_stays_clr", 32'(underrun), 32'(0));

        // Contention with the transmitter busy: alternate grants until full.
        do_reset();
        tx_mode = 2;
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, DW'($urandom()), DW'($urandom()),
                 DW'($urandom()), DW'($urandom()));
        exp_g = '{0, 1, 0, 1};
        chk("cont_ngrants", 32'(grants.size()), 32'(4));
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("cont_order", 32'(grants[i]), 32'(exp_g[i]));
        chk("cont_full", 32'(fifo_count), 32'(4));

        // Drain the full FIFO through a slow transmitter.
        tx_mode  = 1;
        busy_len = 40;
        n_en     = 0;
        idle_steps(220);
        chk("drain_pulses", 32'(n_en), 32'(4));
        chk("drain_empty", 32'(fifo_count), 32'(0));

        // Randomized traffic against two transmitter behaviours.
        do_reset();
        tx_mode = 0;
        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 49) == 0),
                 DW'($urandom()), DW'($urandom()), DW'($urandom()), DW'($urandom()));
        tx_mode = 1;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) busy_len = $urandom_range(1, 6);
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 49) == 0),
                 DW'($urandom()), DW'($urandom()), DW'($urandom()), DW'($urandom()));
        end

        // Reset in the middle of a transmission with three samples queued.
        do_reset();
        tx_mode = 2;
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, DW'($urandom()), DW'($urandom()),
                 DW'($urandom()), DW'($urandom()));
        tx_mode  = 1;
        busy_len = 50;
        idle_steps(4);
        chk("pre_rst_cnt", 32'(fifo_count), 32'(3));
        chk("pre_rst_state", 32'(dbg_state), 32'(2));
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("midrst_en",    32'(tx_enable),  32'(0));
        chk("midrst_dr",    32'(tx_dataR),   32'(0));
        chk("midrst_dl",    32'(tx_dataL),   32'(0));
        chk("midrst_cnt",   32'(fifo_count), 32'(0));
        chk("midrst_rdy0",  32'(req0_ready), 32'(0));
        chk("midrst_rdy1",  32'(req1_ready), 32'(0));
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst        = 1'b1;
        model_reset();
        en_before = n_en;
        idle_steps(20);
        chk("post_rst_no_en", 32'(n_en - en_before), 32'(0));
        step(1'b0, 1'b1, 1'b0, '0, '0, 12'h0C3, 12'h3C0);
        idle_steps(1);
        chk("post_rst_en", 32'(tx_enable), 32'(1));
        chk("post_rst_R",  32'(tx_dataR),  32'(12'h0C3));
        idle_steps(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a wait above never completes.
    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/amp3_scheduler.md
AMP3_SCHEDULER -- requirements
Module: amp3_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, meaning width of one channel sample.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning stereo-sample FIFO entries (power of two, >=2).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 req0_valid  input  1  requester 0 offers a stereo sample.
REQ-006 req0_ready  output  1  requester 0 sample accepted this cycle when req0_valid=1.
REQ-007 req0_R, req0_L  input  DATA_W each  requester 0 right/left samples.
REQ-008 req1_valid, req1_ready, req1_R, req1_L SHALL mirror REQ-005..REQ-007 for requester 1.
REQ-009 tx_enable  output  1  one-cycle start pulse to the I2S transmitter.
REQ-010 tx_dataR, tx_dataL  output  DATA_W each  sample presented to the transmitter, registered.
REQ-011 tx_idle  input  1  transmitter idle (1 = ready for new sample).
REQ-012 fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 underrun  output  1  sticky flag: transmitter went idle with FIFO empty after streaming began.
REQ-014 underrun_clr  input  1  synchronous clear of underrun and of the streaming flag.

Function
REQ-015 Transfer on requester k SHALL occur only when reqk_valid=1 and reqk_ready=1 at the same rising edge.
REQ-016 At most one requester SHALL be granted per cycle; readies SHALL be mutually exclusive and both 0 when FIFO full.
REQ-017 Grant SHALL be round-robin: if only one valid, it is granted; if both valid, the requester not granted last is granted; last_grant register updates only on an actual transfer.
REQ-018 readyk SHALL be combinational from valid inputs, last_grant and full; no combinational path from tx_idle to any ready.
REQ-019 Accepted sample SHALL enter FIFO tail; FIFO order is strict arrival order; pointers wrap modulo DEPTH.
REQ-020 No push when full, even if a pop occurs the same cycle; push and pop in same cycle when non-empty and not full SHALL leave fifo_count unchanged.
REQ-021 Sequencer FSM states: IDLE, WAIT_BUSY, WAIT_IDLE.
REQ-022 IDLE: if FIFO non-empty and tx_idle=1 -> pop head, load tx_dataR/tx_dataL, pulse tx_enable for exactly one cycle, set streaming flag, go WAIT_BUSY; else stay.
REQ-023 WAIT_BUSY: stay until tx_idle=0, then go WAIT_IDLE; tx_enable=0.
REQ-024 WAIT_IDLE: stay until tx_idle=1, then go IDLE; tx_enable=0.
REQ-025 Latency: sample pushed into empty FIFO at edge N with FSM in IDLE and tx_idle=1 SHALL produce tx_enable=1 and loaded tx_data during cycle after edge N+1.
REQ-026 tx_dataR/tx_dataL SHALL hold last loaded value until next load.
REQ-027 underrun SHALL set when FSM in IDLE, streaming flag=1, tx_idle=1 and FIFO empty; remains set until underrun_clr or reset; underrun_clr takes priority over set in the same cycle.
REQ-028 fifo_count SHALL equal pushes minus pops since reset, range 0..DEPTH.

Reset
REQ-029 rst=0 SHALL asynchronously force: FSM IDLE, tx_enable=0, tx_dataR=0, tx_dataL=0, fifo_count=0, underrun=0, streaming flag=0, last_grant=1 (requester 0 wins first tie), both readies 0 while rst=0.
REQ-030 Reset mid-operation SHALL discard FIFO contents and any pending transmission; first grant after release follows REQ-029 values.

Verification
REQ-031 Single source: req0 offers R=A5A,L=468 with tx_idle=1 -> req0_ready=1, next cycle tx_enable pulse one cycle, tx_dataR=A5A, tx_dataL=468, fifo_count returns 0.
REQ-032 Contention: both valid continuously, tx_idle=0 -> accept order req0,req1,req0,req1, FIFO full at 4, both readies 0, fifo_count=4.
REQ-033 Drain: from full FIFO, model transmitter idle low for 40 cycles per sample -> four tx_enable pulses, each only after tx_idle low-then-high, data in arrival order.
REQ-034 Underrun: send one sample, no further input, transmitter returns idle -> underrun=1 and stays; underrun_clr pulse -> underrun=0.
REQ-035 Reset mid-stream: rst=0 while FIFO count=3 and FSM WAIT_IDLE -> immediately tx_enable=0, tx_data=0, fifo_count=0; after release no tx_enable until new push.
